byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/serializer_pkg.sv | 29 ++
 rtl/byte_serializer.sv | 132 +++++++++++++
 tb/tb_byte_serializer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
`default_nettype none
// serializer_pkg: frame constants, state encoding and byte-select helper for byte_serializer.
// The CHKSUM state exists only when SERIALIZER_CHECKSUM_EN is defined.
package serializer_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int         DATA_BYTES = 4;

`ifdef SERIALIZER_CHECKSUM_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_CHKSUM = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;
`endif

    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// byte_serializer: sends a captured 32-bit word as header 0xA5 plus four bytes, LSB first.
// Defining SERIALIZER_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module byte_serializer
    import serializer_pkg::*;
(
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        flush,
    output logic [7:0]  packet_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        header_flag,
    output logic [2:0]  byte_cnt,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BYTES - 1);

    state_t      r_state;
    logic [31:0] r_word;
    logic [7:0]  r_pkt;
    logic        r_valid;
    logic        r_hdr;
    logic        r_busy;
    logic [2:0]  r_cnt;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic [7:0]  w_cur_byte;
    logic [7:0]  w_next_byte;

    // byte_cnt doubles as the index of the data byte currently presented
    assign w_cur_byte  = sel_byte(r_word, r_cnt[1:0]);
    assign w_next_byte = sel_byte(r_word, r_cnt[1:0] + 2'd1);

    assign word_ready  = reset_n && (r_state == S_IDLE) && !flush;
    assign packet_out  = r_pkt;
    assign byte_valid  = r_valid;
    assign header_flag = r_hdr;
    assign byte_cnt    = r_cnt;
    assign busy        = r_busy;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_word  <= 32'h0;
            r_pkt   <= 8'h00;
            r_valid <= 1'b0;
            r_hdr   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= 3'd0;
`ifdef SERIALIZER_CHECKSUM_EN
            r_chk   <= 8'h00;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
            r_pkt   <= 8'h00;
            r_valid <= 1'b0;
            r_hdr   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (word_valid && word_ready) begin
                        r_state <= S_HEADER;
                        r_word  <= word_in;
                        r_pkt   <= HDR_BYTE;
                        r_valid <= 1'b1;
                        r_hdr   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= 3'd0;
`ifdef SERIALIZER_CHECKSUM_EN
                        r_chk   <= 8'h00;
`endif
                    end
                end
                S_HEADER: begin
                    if (byte_ready) begin
                        r_state <= S_DATA;
                        r_pkt   <= w_cur_byte;
                        r_hdr   <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (byte_ready) begin
                        r_cnt <= r_cnt + 3'd1;
`ifdef SERIALIZER_CHECKSUM_EN
                        r_chk <= r_chk ^ w_cur_byte;
`endif
                        if (r_cnt == LAST_IDX) begin
`ifdef SERIALIZER_CHECKSUM_EN
                            r_state <= S_CHKSUM;
                            r_pkt   <= r_chk ^ w_cur_byte;
`else
                            r_state <= S_IDLE;
                            r_pkt   <= 8'h00;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_pkt <= w_next_byte;
                        end
                    end
                end
`ifdef SERIALIZER_CHECKSUM_EN
                S_CHKSUM: begin
                    if (byte_ready) begin
                        r_state <= S_IDLE;
                        r_pkt   <= 8'h00;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_hdr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// tb_byte_serializer: directed self-checking bench for byte_serializer.
module tb_byte_serializer;

`ifdef SERIALIZER_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

    logic        clk_50;
    logic        reset_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        flush;
    logic [7:0]  packet_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        header_flag;
    logic [2:0]  byte_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    byte_serializer dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .flush       (flush),
        .packet_out  (packet_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .header_flag (header_flag),
        .byte_cnt    (byte_cnt),
        .busy        (busy)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic test_reset();
        reset_n    = 1'b0;
        flush      = 1'b0;
        word_valid = 1'b0;
        byte_ready = 1'b1;
        word_in    = 32'h0;
        repeat (2) @(negedge clk_50);
        checks++;
        if ({word_ready, byte_valid, header_flag, busy, byte_cnt, packet_out} !== 14'h0) begin
            errors++;
            $display("FAIL reset_hold: got rdy=%b vld=%b hdr=%b busy=%b cnt=%0d pkt=%h, want all zero",
                     word_ready, byte_valid, header_flag, busy, byte_cnt, packet_out);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", word_ready);
        end
        @(negedge clk_50);
    endtask

    task automatic test_basic();
        logic [7:0] exp_pkt [FRAME_LEN];
        logic [2:0] exp_cnt [FRAME_LEN];
        exp_pkt[0] = 8'hA5; exp_pkt[1] = 8'h11; exp_pkt[2] = 8'h22; exp_pkt[3] = 8'h33; exp_pkt[4] = 8'h44;
        exp_cnt[0] = 3'd0;  exp_cnt[1] = 3'd0;  exp_cnt[2] = 3'd1;  exp_cnt[3] = 3'd2;  exp_cnt[4] = 3'd3;
`ifdef SERIALIZER_CHECKSUM_EN
        exp_pkt[5] = 8'h44; exp_cnt[5] = 3'd4;
`endif
        word_in    = 32'h44332211;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b want 1", word_ready);
        end
        @(negedge clk_50);
        word_valid = 1'b0;
        word_in    = 32'hDEADBEEF;
        for (int i = 0; i < FRAME_LEN; i++) begin
            checks++;
            if ({byte_valid, busy, header_flag, byte_cnt, packet_out} !==
                {1'b1, 1'b1, (i == 0), exp_cnt[i], exp_pkt[i]}) begin
                errors++;
                $display("FAIL basic_byte%0d: got vld=%b busy=%b hdr=%b cnt=%0d pkt=%h, want vld=1 busy=1 hdr=%b cnt=%0d pkt=%h",
                         i, byte_valid, busy, header_flag, byte_cnt, packet_out, (i == 0), exp_cnt[i], exp_pkt[i]);
            end
            @(negedge clk_50);
        end
        checks++;
        if ({byte_valid, busy, header_flag, word_ready, byte_cnt} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL basic_idle: got vld=%b busy=%b hdr=%b rdy=%b cnt=%0d, want vld=0 busy=0 hdr=0 rdy=1 cnt=4",
                     byte_valid, busy, header_flag, word_ready, byte_cnt);
        end
    endtask

    task automatic test_stall();
        word_in    = 32'h44332211;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk_50);
        word_valid = 1'b0;
        @(negedge clk_50);
        @(negedge clk_50);
        checks++;
        if ({packet_out, byte_cnt} !== {8'h22, 3'd1}) begin
            errors++;
            $display("FAIL stall_enter: got pkt=%h cnt=%0d, want pkt=22 cnt=1", packet_out, byte_cnt);
        end
        byte_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_50);
            checks++;
            if ({byte_valid, header_flag, packet_out, byte_cnt} !== {1'b1, 1'b0, 8'h22, 3'd1}) begin
                errors++;
                $display("FAIL stall_hold%0d: got vld=%b hdr=%b pkt=%h cnt=%0d, want vld=1 hdr=0 pkt=22 cnt=1",
                         k, byte_valid, header_flag, packet_out, byte_cnt);
            end
        end
        byte_ready = 1'b1;
        @(negedge clk_50);
        checks++;
        if ({packet_out, byte_cnt} !== {8'h33, 3'd2}) begin
            errors++;
            $display("FAIL stall_resume: got pkt=%h cnt=%0d, want pkt=33 cnt=2", packet_out, byte_cnt);
        end
        @(negedge clk_50);
        checks++;
        if ({packet_out, byte_cnt} !== {8'h44, 3'd3}) begin
            errors++;
            $display("FAIL stall_last: got pkt=%h cnt=%0d, want pkt=44 cnt=3", packet_out, byte_cnt);
        end
        repeat (FRAME_LEN - 4) @(negedge clk_50);
        checks++;
        if ({byte_valid, word_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_idle: got vld=%b rdy=%b, want vld=0 rdy=1", byte_valid, word_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f1 [FRAME_LEN];
        logic [7:0] f2 [FRAME_LEN];
        f1[0] = 8'hA5; f1[1] = 8'hAA; f1[2] = 8'hBB; f1[3] = 8'hCC; f1[4] = 8'hDD;
        f2[0] = 8'hA5; f2[1] = 8'h01; f2[2] = 8'h02; f2[3] = 8'h03; f2[4] = 8'h04;
`ifdef SERIALIZER_CHECKSUM_EN
        f1[5] = 8'h00; f2[5] = 8'h04;
`endif
        word_in    = 32'hDDCCBBAA;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk_50);
        word_in = 32'h04030201;
        for (int i = 0; i < FRAME_LEN; i++) begin
            checks++;
            if ({byte_valid, header_flag, word_ready, packet_out} !== {1'b1, (i == 0), 1'b0, f1[i]}) begin
                errors++;
                $display("FAIL b2b_f1_byte%0d: got vld=%b hdr=%b rdy=%b pkt=%h, want vld=1 hdr=%b rdy=0 pkt=%h",
                         i, byte_valid, header_flag, word_ready, packet_out, (i == 0), f1[i]);
            end
            @(negedge clk_50);
        end
        checks++;
        if ({byte_valid, word_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: got vld=%b rdy=%b, want vld=0 rdy=1", byte_valid, word_ready);
        end
        @(negedge clk_50);
        word_valid = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            checks++;
            if ({byte_valid, header_flag, packet_out} !== {1'b1, (i == 0), f2[i]}) begin
                errors++;
                $display("FAIL b2b_f2_byte%0d: got vld=%b hdr=%b pkt=%h, want vld=1 hdr=%b pkt=%h",
                         i, byte_valid, header_flag, packet_out, (i == 0), f2[i]);
            end
            @(negedge clk_50);
        end
        checks++;
        if ({byte_valid, busy, word_ready} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_end: got vld=%b busy=%b rdy=%b, want vld=0 busy=0 rdy=1", byte_valid, busy, word_ready);
        end
    endtask

    task automatic test_flush();
        word_in    = 32'h44332211;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk_50);
        word_valid = 1'b0;
        repeat (3) @(negedge clk_50);
        checks++;
        if (packet_out !== 8'h33) begin
            errors++;
            $display("FAIL flush_pre: got pkt=%h want 33", packet_out);
        end
        flush = 1'b1;
        @(negedge clk_50);
        flush = 1'b0;
        #1;
        checks++;
        if ({byte_valid, busy, byte_cnt, word_ready} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL flush_idle: got vld=%b busy=%b cnt=%0d rdy=%b, want vld=0 busy=0 cnt=0 rdy=1",
                     byte_valid, busy, byte_cnt, word_ready);
        end
        flush      = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'h01020304;
        #1;
        checks++;
        if (word_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready: got %b want 0", word_ready);
        end
        @(negedge clk_50);
        checks++;
        if ({byte_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_no_accept: got vld=%b busy=%b, want vld=0 busy=0", byte_valid, busy);
        end
        flush = 1'b0;
        #1;
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready_back: got %b want 1", word_ready);
        end
        @(negedge clk_50);
        word_valid = 1'b0;
        checks++;
        if ({byte_valid, header_flag, packet_out} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL flush_next_hdr: got vld=%b hdr=%b pkt=%h, want vld=1 hdr=1 pkt=a5",
                     byte_valid, header_flag, packet_out);
        end
        @(negedge clk_50);
        checks++;
        if (packet_out !== 8'h04) begin
            errors++;
            $display("FAIL flush_next_byte0: got pkt=%h want 04", packet_out);
        end
        repeat (FRAME_LEN - 1) @(negedge clk_50);
        checks++;
        if (byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_next_end: got vld=%b want 0", byte_valid);
        end
    endtask

`ifdef SERIALIZER_CHECKSUM_EN
    task automatic test_checksum_ff();
        word_in    = 32'hFFFFFFFF;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk_50);
        word_valid = 1'b0;
        repeat (5) @(negedge clk_50);
        checks++;
        if ({byte_valid, header_flag, byte_cnt, packet_out} !== {1'b1, 1'b0, 3'd4, 8'h00}) begin
            errors++;
            $display("FAIL chk_ff: got vld=%b hdr=%b cnt=%0d pkt=%h, want vld=1 hdr=0 cnt=4 pkt=00",
                     byte_valid, header_flag, byte_cnt, packet_out);
        end
        @(negedge clk_50);
    endtask
`endif

    task automatic test_reset_mid();
        word_in    = 32'h44332211;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk_50);
        word_valid = 1'b0;
        repeat (2) @(negedge clk_50);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({word_ready, byte_valid, header_flag, busy, byte_cnt, packet_out} !== 14'h0) begin
            errors++;
            $display("FAIL reset_async: got rdy=%b vld=%b hdr=%b busy=%b cnt=%0d pkt=%h, want all zero",
                     word_ready, byte_valid, header_flag, busy, byte_cnt, packet_out);
        end
        @(negedge clk_50);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({word_ready, byte_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_release: got rdy=%b vld=%b, want rdy=1 vld=0", word_ready, byte_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50);
            checks++;
            if ({byte_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_quiet%0d: got vld=%b busy=%b, want 0 0", k, byte_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
`ifdef SERIALIZER_CHECKSUM_EN
        test_checksum_ff();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
